keypad_lock: RTL and testbench

- Parametrised keypad lock controller; successor to the fixed 8-digit, single-attempt lock FSM.
- Adds programmable code length, a retry budget with timed lockout, open-state auto-relock, and an abort key.
- Sits between the key encoder/synchroniser (5-bit key code plus level strobe) and the display/LED driver.
- Runs on the system clock rather than on the key strobe.

---
 rtl/keylock_pkg.sv | 14 +
 rtl/keylock_timer.sv | 31 +++
 rtl/keypad_lock.sv | 191 +++++++++++++++++++
 tb/tb_keypad_lock.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keylock_pkg.sv
// keylock_pkg: state encoding and key constants shared by keypad_lock and its bench
package keylock_pkg;
    typedef enum logic [2:0] {
        SET     = 3'd0,
        LOCKED  = 3'd1,
        ENTRY   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4,
        ALARM   = 3'd5
    } state_t;
    localparam logic [4:0] KEY_W = 5'd16;
    localparam logic [4:0] KEY_X = 5'd17;
    localparam logic [4:0] KEY_Y = 5'd18;
endpackage

// File: rtl/keylock_timer.sv
// keylock_timer: loadable down-counter shared by the LOCKOUT and OPEN states
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load i_load_val (wins over i_clear)
//   i_clear      : force the count to 0
//   o_value      : current count; free-runs down to 0 and holds there
//   o_expire     : high while the count is 1 (last cycle of the interval)
module keylock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_expire
);
    logic [W-1:0] r_value;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_value <= '0;
        else if (i_load)
            r_value <= i_load_val;
        else if (i_clear)
            r_value <= '0;
        else if (r_value != '0)
            r_value <= r_value - 1'b1;
    end
    assign o_value  = r_value;
    assign o_expire = (r_value == W'(1));
endmodule

// File: rtl/keypad_lock.sv
// keypad_lock: parametrised keypad lock with retry budget, timed lockout and auto-relock
//   clk, rst       : system clock, asynchronous active-high reset
//   i_key_strobe   : level, high while a key is held; one acceptance per rising edge
//   i_key_code     : 0-15 digit, 16 W, 17 X, 18 Y, 19 unused
//   o_state        : current state_t
//   o_code         : stored code, first entered digit in the MS nibble
//   o_digit_idx    : digits accepted in the current SET/ENTRY
//   o_tries_left   : remaining attempts
//   o_timer        : remaining cycles in LOCKOUT/OPEN, else 0
//   o_unlocked, o_alarm, o_locked_out : registered state decodes
// Optional: KEYPAD_LOCK_CHANGE_EN lets Y in OPEN return to SET for a new code.
module keypad_lock
    import keylock_pkg::*;
#(
    parameter int CODE_LEN      = 8,
    parameter int MAX_TRIES     = 3,
    parameter int LOCKOUT_TICKS = 500,
    parameter int OPEN_TICKS    = 1000,
    localparam int CW  = 4 * CODE_LEN,
    localparam int IW  = $clog2(CODE_LEN + 1),
    localparam int TRW = $clog2(MAX_TRIES + 1),
    localparam int TW  = $clog2((LOCKOUT_TICKS > OPEN_TICKS ? LOCKOUT_TICKS : OPEN_TICKS) + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_key_strobe,
    input  logic [4:0]     i_key_code,
    output logic [2:0]     o_state,
    output logic [CW-1:0]  o_code,
    output logic [IW-1:0]  o_digit_idx,
    output logic [TRW-1:0] o_tries_left,
    output logic [TW-1:0]  o_timer,
    output logic           o_unlocked,
    output logic           o_alarm,
    output logic           o_locked_out
);
    state_t         r_state, w_state;
    logic [CW-1:0]  r_code, w_code;
    logic [IW-1:0]  r_idx, w_idx;
    logic [TRW-1:0] r_tries, w_tries;
    logic           r_bad, w_bad;
    logic           r_strobe, r_unlocked, r_alarm, r_locked_out;
    logic           w_load, w_clear, w_expire;
    logic [TW-1:0]  w_load_val, w_timer;
    logic [3:0]     w_exp;
    logic           w_acc, w_digit, w_key_w, w_key_x, w_miss;

    assign w_acc   = i_key_strobe & ~r_strobe;
    assign w_digit = w_acc & ~i_key_code[4];
    assign w_key_w = w_acc && (i_key_code == KEY_W);
    assign w_key_x = w_acc && (i_key_code == KEY_X);
`ifdef KEYPAD_LOCK_CHANGE_EN
    logic w_key_y;
    assign w_key_y = w_acc && (i_key_code == KEY_Y);
`endif

    // Expected digit for the current entry position, MS digit first.
    always_comb begin
        w_exp = '0;
        for (int k = 0; k < CODE_LEN; k++)
            if (r_idx == IW'(k)) w_exp = r_code[4*(CODE_LEN-1-k) +: 4];
    end
    // Sticky mismatch including the digit being accepted now.
    assign w_miss = r_bad | (i_key_code[3:0] != w_exp);

    always_comb begin
        w_state    = r_state;
        w_code     = r_code;
        w_idx      = r_idx;
        w_tries    = r_tries;
        w_bad      = r_bad;
        w_load     = 1'b0;
        w_load_val = '0;
        w_clear    = 1'b0;
        case (r_state)
            SET: begin
                if (w_digit) begin
                    w_code = CW'({r_code, i_key_code[3:0]});
                    w_idx  = (r_idx == IW'(CODE_LEN)) ? r_idx : r_idx + 1'b1;
                end else if (w_key_w && r_idx == IW'(CODE_LEN)) begin
                    w_state = LOCKED;
                    w_idx   = '0;
                end else if (w_key_x) begin
                    w_code = '0;
                    w_idx  = '0;
                end
            end
            LOCKED: begin
                if (w_key_w) begin
                    w_state = ENTRY;
                    w_idx   = '0;
                    w_bad   = 1'b0;
                end
            end
            ENTRY: begin
                if (w_digit) begin
                    if (r_idx == IW'(CODE_LEN - 1)) begin
                        w_idx = '0;
                        w_bad = 1'b0;
                        if (!w_miss) begin
                            w_state    = OPEN;
                            w_tries    = TRW'(MAX_TRIES);
                            w_load     = 1'b1;
                            w_load_val = TW'(OPEN_TICKS);
                        end else begin
                            w_tries = r_tries - 1'b1;
                            if (r_tries == TRW'(1)) begin
                                w_state = ALARM;
                            end else begin
                                w_state    = LOCKOUT;
                                w_load     = 1'b1;
                                w_load_val = TW'(LOCKOUT_TICKS);
                            end
                        end
                    end else begin
                        w_idx = r_idx + 1'b1;
                        w_bad = w_miss;
                    end
                end else if (w_key_x) begin
                    w_state = LOCKED;
                    w_idx   = '0;
                end else if (w_key_w) begin
                    w_idx = '0;
                    w_bad = 1'b0;
                end
            end
            // The timer runs down to 0 by itself, so leaving on expiry needs no clear.
            LOCKOUT: begin
                if (w_expire) w_state = LOCKED;
            end
            OPEN: begin
                if (w_expire || w_key_w) begin
                    w_state = LOCKED;
                    w_clear = 1'b1;
                end
`ifdef KEYPAD_LOCK_CHANGE_EN
                else if (w_key_y) begin
                    w_state = SET;
                    w_code  = '0;
                    w_idx   = '0;
                    w_clear = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe     <= 1'b0;
            r_state      <= SET;
            r_code       <= '0;
            r_idx        <= '0;
            r_tries      <= TRW'(MAX_TRIES);
            r_bad        <= 1'b0;
            r_unlocked   <= 1'b0;
            r_alarm      <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_strobe     <= i_key_strobe;
            r_state      <= w_state;
            r_code       <= w_code;
            r_idx        <= w_idx;
            r_tries      <= w_tries;
            r_bad        <= w_bad;
            r_unlocked   <= (w_state == OPEN);
            r_alarm      <= (w_state == ALARM);
            r_locked_out <= (w_state == LOCKOUT);
        end
    end

    keylock_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_load_val (w_load_val),
        .o_value    (w_timer),
        .o_expire   (w_expire)
    );

    assign o_state      = r_state;
    assign o_code       = r_code;
    assign o_digit_idx  = r_idx;
    assign o_tries_left = r_tries;
    assign o_timer      = w_timer;
    assign o_unlocked   = r_unlocked;
    assign o_alarm      = r_alarm;
    assign o_locked_out = r_locked_out;
endmodule

// File: tb/tb_keypad_lock.sv
// tb_keypad_lock: directed bench for keypad_lock with a sequence-level reference model
module tb_keypad_lock;
    import keylock_pkg::*;
    localparam int L = 4, MT = 3, LT = 500, OT = 1000;
    localparam int IW = $clog2(L + 1), TRW = $clog2(MT + 1), TW = $clog2(OT + 1);

    logic           clk = 1'b0, rst = 1'b1, strobe = 1'b0;
    logic [4:0]     key = '0;
    logic [2:0]     st;
    logic [4*L-1:0] code;
    logic [IW-1:0]  idx;
    logic [TRW-1:0] tries;
    logic [TW-1:0]  timer;
    logic           unl, alm, lko;
    int             errors = 0, checks = 0;

    keypad_lock #(.CODE_LEN(L), .MAX_TRIES(MT), .LOCKOUT_TICKS(LT), .OPEN_TICKS(OT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_key_strobe (strobe),
        .i_key_code   (key),
        .o_state      (st),
        .o_code       (code),
        .o_digit_idx  (idx),
        .o_tries_left (tries),
        .o_timer      (timer),
        .o_unlocked   (unl),
        .o_alarm      (alm),
        .o_locked_out (lko)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stored code and the current attempt are digit queues,
    // an attempt is judged as a whole sequence, timers are absolute deadlines.
    int m_st, m_tries, m_cyc = 0, m_end = 0;
    int m_code[$], m_try[$];
    bit m_prev, m_acc, m_ok;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = SET; m_code.delete(); m_try.delete(); m_tries = MT; m_prev = 0;
        end else begin
            m_acc = strobe && !m_prev;
            m_prev = strobe;
            m_cyc++;
            case (m_st)
                SET: begin
                    if (m_acc && key < 16) begin
                        m_code.push_back(int'(key));
                        if (m_code.size() > L) void'(m_code.pop_front());
                    end else if (m_acc && key == 16 && m_code.size() == L) m_st = LOCKED;
                    else if (m_acc && key == 17) m_code.delete();
                end
                LOCKED: if (m_acc && key == 16) begin m_st = ENTRY; m_try.delete(); end
                ENTRY: begin
                    if (m_acc && key < 16) begin
                        m_try.push_back(int'(key));
                        if (m_try.size() == L) begin
                            m_ok = 1;
                            foreach (m_try[i]) if (m_try[i] != m_code[i]) m_ok = 0;
                            if (m_ok) begin
                                m_st = OPEN; m_tries = MT; m_end = m_cyc + OT;
                            end else begin
                                m_tries--;
                                if (m_tries == 0) m_st = ALARM;
                                else begin m_st = LOCKOUT; m_end = m_cyc + LT; end
                            end
                            m_try.delete();
                        end
                    end else if (m_acc && key == 17) begin m_st = LOCKED; m_try.delete(); end
                    else if (m_acc && key == 16) m_try.delete();
                end
                LOCKOUT: if (m_cyc == m_end) m_st = LOCKED;
                OPEN: begin
                    if (m_cyc == m_end || (m_acc && key == 16)) m_st = LOCKED;
`ifdef KEYPAD_LOCK_CHANGE_EN
                    else if (m_acc && key == 18) begin m_st = SET; m_code.delete(); end
`endif
                end
                default: ;
            endcase
        end
    end

    int e_code;
    always @(negedge clk) begin
        e_code = 0;
        foreach (m_code[i]) e_code = (e_code << 4) | m_code[i];
        chk("state", 32'(st), 32'(m_st));
        chk("code", 32'(code), 32'(e_code));
        chk("digit_idx", 32'(idx), m_st == SET ? m_code.size() : m_st == ENTRY ? m_try.size() : 0);
        chk("tries_left", 32'(tries), 32'(m_tries));
        chk("timer", 32'(timer), (m_st == LOCKOUT || m_st == OPEN) ? m_end - m_cyc : 0);
        chk("unlocked", 32'(unl), 32'(m_st == OPEN));
        chk("alarm", 32'(alm), 32'(m_st == ALARM));
        chk("locked_out", 32'(lko), 32'(m_st == LOCKOUT));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk); strobe = 1'b1; key = k;
        @(negedge clk); strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic attempt(input logic [15:0] c);
        press(5'd16);
        for (int i = 3; i >= 0; i--) press({1'b0, c[4*i +: 4]});
    endtask

    initial begin
        cyc(3); rst = 1'b0;
        chk("lit_rst_state", 32'(st), 32'(SET));
        chk("lit_rst_tries", 32'(tries), 3);
        chk("lit_rst_code", 32'(code), 0);
        // held key gives one acceptance
        @(negedge clk); strobe = 1'b1; key = 5'd7;
        cyc(50); strobe = 1'b0; cyc(1);
        chk("lit_hold_idx", 32'(idx), 1);
        chk("lit_hold_code", 32'(code), 32'h7);
        press(5'd17);
        for (int d = 1; d <= 5; d++) press(5'(d));
        chk("lit_sat_code", 32'(code), 32'h2345);
        chk("lit_sat_idx", 32'(idx), 4);
        press(5'd17);
        press(5'd1); press(5'd2); press(5'd3); press(5'd16);
        chk("lit_short_w", 32'(st), 32'(SET));
        press(5'd4); press(5'd19); press(5'd18); press(5'd16);
        chk("lit_locked", 32'(st), 32'(LOCKED));
        chk("lit_code", 32'(code), 32'h1234);
        press(5'd19);
        press(5'd16); press(5'd1); press(5'd2);
        chk("lit_entry_idx", 32'(idx), 2);
        press(5'd17);
        chk("lit_abort", 32'(st), 32'(LOCKED));
        chk("lit_abort_tries", 32'(tries), 3);
        attempt(16'h1234);
        chk("lit_open", 32'(st), 32'(OPEN));
        chk("lit_open_unl", 32'(unl), 1);
        chk("lit_open_timer", 32'(timer), 999);
        press(5'd16);
        chk("lit_w_relock", 32'(st), 32'(LOCKED));
        attempt(16'h1235);
        chk("lit_lockout", 32'(st), 32'(LOCKOUT));
        chk("lit_lockout_tries", 32'(tries), 2);
        chk("lit_lockout_timer", 32'(timer), 499);
        press(5'd1); press(5'd16);
        chk("lit_lockout_keys", 32'(timer), 493);
        cyc(492);
        chk("lit_lockout_last", 32'(st), 32'(LOCKOUT));
        cyc(1);
        chk("lit_lockout_end", 32'(st), 32'(LOCKED));
        attempt(16'h1234);
        chk("lit_tries_restore", 32'(tries), 3);
        cyc(998);
        chk("lit_open_last", 32'(timer), 1);
        cyc(1);
        chk("lit_open_timeout", 32'(st), 32'(LOCKED));
        press(5'd16); press(5'd5); press(5'd5);
        attempt(16'h1234);
        chk("lit_restart", 32'(st), 32'(OPEN));
        press(5'd16);
        attempt(16'h9999); cyc(500);
        attempt(16'h9999); cyc(500);
        chk("lit_tries_1", 32'(tries), 1);
        attempt(16'h9999);
        chk("lit_alarm", 32'(alm), 1);
        chk("lit_alarm_tries", 32'(tries), 0);
        press(5'd16); attempt(16'h1234);
        chk("lit_alarm_stuck", 32'(st), 32'(ALARM));
        @(negedge clk); #3 rst = 1'b1; #1;
        chk("lit_async_state", 32'(st), 32'(SET));
        chk("lit_async_alarm", 32'(alm), 0);
        @(negedge clk); rst = 1'b0;
        for (int d = 1; d <= 4; d++) press(5'(d));
        press(5'd16);
        attempt(16'h1234);
        press(5'd18);
`ifdef KEYPAD_LOCK_CHANGE_EN
        chk("lit_change_set", 32'(st), 32'(SET));
        chk("lit_change_timer", 32'(timer), 0);
        for (int d = 0; d < 4; d++) press(5'd9);
        press(5'd16);
        chk("lit_change_locked", 32'(st), 32'(LOCKED));
        chk("lit_change_code", 32'(code), 32'h9999);
`else
        chk("lit_y_ignored", 32'(st), 32'(OPEN));
        chk("lit_y_code", 32'(code), 32'h1234);
`endif
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
